// File: rtl/bram_fifo_pkg.sv
// Shared sizing for the BRAM-backed stream FIFO: address/data widths,
// depth, output-buffer size and the occupancy type.
package bram_fifo_pkg;

    localparam int FIFO_AW    = 12;
    localparam int FIFO_DW    = 4;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int FIFO_OBUF  = 2;

    // Occupancy can reach DEPTH + OBUF, hence two bits beyond the address.
    typedef logic [FIFO_AW+1:0] level_t;

endpackage

// File: rtl/bram_fifo_obuf.sv
// Two-entry output buffer fed by BRAM read data; entry 0 is always the head,
// so the presented word only changes on a pop.
module bram_fifo_obuf
    import bram_fifo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic [1:0]    cnt_o
);

    logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]    cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = din_i;
                    else               e1_d = din_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din_i;
                    end else begin
                        e0_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o  = e0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/bram_stream_fifo_ctrl.sv
// Stream FIFO controller for an external dual-port BRAM: writes on port 0,
// prefetching reads on port 1 into a 2-entry buffer for 1 word/cycle output.
module bram_stream_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int DW = FIFO_DW
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CLR,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic [AW+1:0] LEVEL,
    output logic [AW-1:0] A0,
    output logic [DW-1:0] D0,
    output logic          WE0,
    output logic          CE0,
    output logic [DW-1:0] WEM0,
    output logic [AW-1:0] A1,
    output logic          CE1,
    output logic          WE1,
    output logic [DW-1:0] D1,
    output logic [DW-1:0] WEM1,
    input  logic [DW-1:0] Q1
);

    localparam logic [AW:0] DEPTH_CNT  = (AW+1)'(1 << AW);
    localparam logic [2:0]  OBUF_SLOTS = 3'(FIFO_OBUF);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic          inflight_q, inflight_d;
    logic [AW+1:0] level_q, level_d;
    logic [1:0]    obuf_cnt, obuf_cnt_d;
    logic [2:0]    reserved;
    logic          wr_fire, rd_issue, capture, pop;

    always_comb begin
        IN_READY = RSTN && (mem_cnt_q != DEPTH_CNT) && !CLR;
        wr_fire  = IN_VALID && IN_READY;
        pop      = OUT_VALID && OUT_READY;
        capture  = inflight_q && !CLR;
        // Only issue a read if its word is guaranteed a buffer slot on arrival.
        reserved = {1'b0, obuf_cnt} + {2'b00, inflight_q};
        rd_issue = RSTN && (mem_cnt_q != '0) && !CLR &&
                   (reserved < OBUF_SLOTS + {2'b00, pop});

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        inflight_d = 1'b0;
        obuf_cnt_d = 2'd0;
        if (!CLR) begin
            wr_ptr_d   = wr_ptr_q + AW'(wr_fire);
            rd_ptr_d   = rd_ptr_q + AW'(rd_issue);
            mem_cnt_d  = mem_cnt_q + (AW+1)'(wr_fire) - (AW+1)'(rd_issue);
            inflight_d = rd_issue;
            obuf_cnt_d = obuf_cnt + 2'(capture) - 2'(pop);
        end else begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            mem_cnt_d = '0;
        end
        level_d = (AW+2)'(mem_cnt_d) + (AW+2)'(inflight_d) + (AW+2)'(obuf_cnt_d);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            level_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
        end
    end

    bram_fifo_obuf #(.DW(DW)) u_obuf (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .clr_i   (CLR),
        .push_i  (capture),
        .din_i   (Q1),
        .pop_i   (pop),
        .dout_o  (OUT_DATA),
        .valid_o (OUT_VALID),
        .cnt_o   (obuf_cnt)
    );

    assign A0    = wr_ptr_q;
    assign D0    = IN_DATA;
    assign WE0   = wr_fire;
    assign CE0   = wr_fire;
    assign WEM0  = '1;
    assign A1    = rd_ptr_q;
    assign CE1   = rd_issue;
    assign WE1   = 1'b0;
    assign D1    = '0;
    assign WEM1  = '0;
    assign LEVEL = level_q;

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Scoreboard bench for bram_stream_fifo_ctrl with a behavioural 4096x4 BRAM
// wired to its ports; accepted inputs are queued and compared as they emerge.
module tb_bram_stream_fifo_ctrl;
    import bram_fifo_pkg::*;

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic         CLR = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [3:0]   IN_DATA = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [3:0]   OUT_DATA;
    level_t       LEVEL;
    logic [11:0]  A0, A1;
    logic [3:0]   D0, WEM0, D1, WEM1, Q1;
    logic         WE0, CE0, CE1, WE1;

    logic [3:0]   mem [4096];
    logic [3:0]   sbQ [$];
    int           checkCnt = 0;
    int           passCnt = 0;
    int           cyc = 0;
    bit           track = 1'b0;
    int           trkFirst = -1, trkLast = -1, trkPops = 0, trkFires = 0;

    bram_stream_fifo_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .CLR(CLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .LEVEL(LEVEL),
        .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0), .WEM0(WEM0),
        .A1(A1), .CE1(CE1), .WE1(WE1), .D1(D1), .WEM1(WEM1), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    initial Q1 = '0;
    always @(posedge CLK) begin
        if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1) Q1 <= mem[A1];
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: compare pops first, then flush on clear/reset, then record fires.
    always @(negedge CLK) begin
        logic [3:0] exp;
        cyc++;
        if (!RSTN) begin
            sbQ.delete();
        end else begin
            if (CE0 && CE1) checkOutput("port_collision", {31'd0, A0 == A1}, 32'd0);
            if (OUT_VALID && OUT_READY) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_pop", {28'd0, OUT_DATA}, 32'hFFFF);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("out_data", {28'd0, OUT_DATA}, {28'd0, exp});
                end
                if (track) begin
                    if (trkFirst < 0) trkFirst = cyc;
                    trkLast = cyc;
                    trkPops++;
                end
            end
            if (CLR) sbQ.delete();
            else if (IN_VALID && IN_READY) begin
                sbQ.push_back(IN_DATA);
                if (track) trkFires++;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] d);
        bit acc = 1'b0;
        IN_DATA  = d;
        IN_VALID = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge CLK);
            acc = IN_READY;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        if (!acc) checkOutput("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain(input int bound);
        int k = 0;
        while ((sbQ.size() != 0 || OUT_VALID) && k < bound) begin
            @(posedge CLK);
            #1;
            k++;
        end
        checkOutput("drain_empty", sbQ.size(), 32'd0);
    endtask

    initial begin
        int n;
        // Reset values and tie-offs.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        checkOutput("rst_out_data", {28'd0, OUT_DATA}, 32'd0);
        checkOutput("rst_level", {18'd0, LEVEL}, 32'd0);
        checkOutput("rst_ce", {30'd0, CE0, CE1}, 32'd0);
        checkOutput("tie_offs", {WEM0, WEM1, D1, 3'd0, WE1}, 32'hF000);
        @(posedge CLK); #1 RSTN = 1'b1;
        @(negedge CLK);
        checkOutput("in_ready_after_rst", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        // Reset mid-stream with 5 words held.
        for (int i = 1; i <= 5; i++) applyStimulus(4'(i));
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("level_5", {18'd0, LEVEL}, 32'd5);
        RSTN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        checkOutput("midrst_level", {18'd0, LEVEL}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, IN_READY}, 32'd0);
        @(posedge CLK); #1 RSTN = 1'b1;
        @(negedge CLK);
        checkOutput("midrst_release_ready", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        // Single word latency.
        OUT_READY = 1'b1;
        applyStimulus(4'hA);
        n = 1;
        while (n < 20) begin
            @(negedge CLK);
            if (OUT_VALID) break;
            @(posedge CLK);
            n++;
        end
        checkOutput("latency", n, 32'd3);
        checkOutput("single_data", {28'd0, OUT_DATA}, 32'hA);
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("single_level_0", {18'd0, LEVEL}, 32'd0);
        @(posedge CLK); #1;

        // Fill to capacity with output stalled, then drain.
        OUT_READY = 1'b0;
        for (int i = 0; i < 4098; i++) applyStimulus(4'(i % 16));
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("full_in_ready", {31'd0, IN_READY}, 32'd0);
        checkOutput("full_level", {18'd0, LEVEL}, 32'd4098);
        IN_DATA = 4'h7; IN_VALID = 1'b1;
        repeat (3) @(posedge CLK);
        #1 IN_VALID = 1'b0;
        checkOutput("full_level_hold", {18'd0, LEVEL}, 32'd4098);
        OUT_READY = 1'b1;
        waitDrain(6000);
        @(negedge CLK);
        checkOutput("drain_level", {18'd0, LEVEL}, 32'd0);
        @(posedge CLK); #1;

        // Continuous streaming across pointer wrap.
        track = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            IN_DATA  = 4'((i * 7 + 3) % 16);
            IN_VALID = 1'b1;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        waitDrain(100);
        track = 1'b0;
        checkOutput("stream_fires", trkFires, 32'd10000);
        checkOutput("stream_pops", trkPops, 32'd10000);
        checkOutput("stream_span", trkLast - trkFirst, 32'd9999);

        // Random handshakes.
        for (int i = 0; i < 20000; i++) begin
            IN_VALID  = $urandom_range(0, 1) == 1;
            OUT_READY = $urandom_range(0, 1) == 1;
            IN_DATA   = 4'($urandom_range(0, 15));
            @(posedge CLK);
            #1;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        waitDrain(6000);

        // Clear with a read in flight and a buffered word.
        OUT_READY = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(4'(i));
        repeat (4) @(posedge CLK);
        #1 OUT_READY = 1'b1;
        @(negedge CLK);
        checkOutput("preclr_level", {18'd0, LEVEL}, 32'd4);
        @(posedge CLK);
        #1 OUT_READY = 1'b0;
        CLR = 1'b1;
        @(negedge CLK);
        checkOutput("clr_cycle_level", {18'd0, LEVEL}, 32'd3);
        checkOutput("clr_in_ready", {31'd0, IN_READY}, 32'd0);
        @(posedge CLK); #1 CLR = 1'b0;
        @(negedge CLK);
        checkOutput("postclr_out_valid", {31'd0, OUT_VALID}, 32'd0);
        checkOutput("postclr_level", {18'd0, LEVEL}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("postclr_discard", {31'd0, OUT_VALID}, 32'd0);
        applyStimulus(4'h5);
        n = 0;
        while (!OUT_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput("postclr_first_word", {28'd0, OUT_DATA}, 32'h5);
        OUT_READY = 1'b1;
        waitDrain(20);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
